// File: rtl/baudgen_pkg.sv
// rtl/baudgen_pkg.sv - control-word field positions and rate helpers for baudgen_frac
package baudgen_pkg;

  localparam int DIV_LSB  = 16;
  localparam int DIV_MSB  = 31;
  localparam int FRAC_LSB = 0;

  // K = clkfreq * 2^fbits / (baud * os), truncated; DIV = K >> fbits, FRAC = K mod 2^fbits
  function automatic longint baud_k(longint clkfreq, longint baud, longint os, int fbits);
    return (clkfreq << fbits) / (baud * os);
  endfunction

  function automatic int os_width(int os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/frac_divider.sv
// rtl/frac_divider.sv - fractional-N sample-period counter with pending/active rate registers
// BAUDGEN_FRAC_EN adds the FRAC accumulator; without it the period is max(DIV,1).
module frac_divider
  import baudgen_pkg::*;
#(
  parameter int CLKFREQ    = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] control,
  input  logic        control_we,
  output logic        tick
);

  localparam int CW = DIV_W + 1;
  localparam longint K = baud_k(CLKFREQ, BAUD, OVERSAMPLE, FRAC_BITS);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(K >> FRAC_BITS);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    p_last;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] div_m1;
  logic             pend;
  logic             wrap;
  logic             commit;
  logic             unused_ctl;

  assign unused_ctl = ^control[DIV_LSB-1:0];

  // DIV of zero runs at one tick per clock
  assign div_m1 = (div_act == '0) ? '0 : div_act - DIV_W'(1);
  assign wrap   = enable && (cnt == p_last);
  assign commit = pend && (wrap || !enable);
  assign tick   = wrap;

`ifdef BAUDGEN_FRAC_EN
  localparam logic [FRAC_BITS-1:0] FRAC_RST = FRAC_BITS'(K);

  logic [FRAC_BITS-1:0] acc;
  logic [FRAC_BITS-1:0] frac_act;
  logic [FRAC_BITS-1:0] frac_pend;
  logic                 carry_q;

  assign p_last = {1'b0, div_m1} + CW'(carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carry_q   <= 1'b0;
      frac_act  <= FRAC_RST;
      frac_pend <= '0;
    end else begin
      if (!enable) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end else if (wrap) begin
        {carry_q, acc} <= {1'b0, acc} + {1'b0, frac_act};
      end
      if (commit)
        frac_act <= frac_pend;
      if (control_we)
        frac_pend <= control[FRAC_LSB +: FRAC_BITS];
    end
  end
`else
  assign p_last = {1'b0, div_m1};
`endif

  // a write landing on the commit edge stays pending while the older value commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= DIV_RST;
      div_pend <= '0;
      pend     <= 1'b0;
    end else begin
      if (!enable || wrap)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (commit)
        div_act <= div_pend;
      if (control_we) begin
        div_pend <= DIV_W'(control[DIV_MSB:DIV_LSB]);
        pend     <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/baudgen_frac.sv
// rtl/baudgen_frac.sv - programmable fractional-N UART baud generator (sampleclk / baudclk)
// BAUDGEN_FRAC_EN enables the fractional accumulator inside frac_divider.
module baudgen_frac
  import baudgen_pkg::*;
#(
  parameter int CLKFREQ    = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] control,
  input  logic        control_we,
  output logic        sampleclk,
  output logic        baudclk
);

  localparam int OS_W = os_width(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic            tick;
  logic            os_wrap;
  logic [OS_W-1:0] oscnt;

  frac_divider #(
    .CLKFREQ    (CLKFREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W),
    .FRAC_BITS  (FRAC_BITS)
  ) u_frac_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .control    (control),
    .control_we (control_we),
    .tick       (tick)
  );

  assign os_wrap = (oscnt == OS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oscnt     <= '0;
      sampleclk <= 1'b0;
      baudclk   <= 1'b0;
    end else if (!enable) begin
      oscnt     <= '0;
      sampleclk <= 1'b0;
      baudclk   <= 1'b0;
    end else begin
      sampleclk <= tick;
      baudclk   <= tick && os_wrap;
      if (tick)
        oscnt <= os_wrap ? '0 : oscnt + OS_W'(1);
    end
  end

endmodule
